// File: rtl/ascon_dec.sv
// Ascon-128 decryption engine, one permutation round per clock.
// Full 64-bit AD/CT blocks only; plaintext is released ahead of the tag check.
module ascon_p (
   input  logic [4:0][63:0] x,
   input  logic [7:0]       c_r,
   output logic [4:0][63:0] y
);
   function automatic logic [63:0] ror(
      input logic [63:0] v,
      input int unsigned n
   );
      return (v >> n) | (v << (64 - n));
   endfunction

   logic [4:0][63:0] a;
   logic [4:0][63:0] s;

   // constant addition followed by the 5-bit S-box, bit-sliced over 64 lanes
   always_comb begin
      a    = x;
      a[2] = x[2] ^ {56'd0, c_r};
      a[0] = a[0] ^ a[4];
      a[4] = a[4] ^ a[3];
      a[2] = a[2] ^ a[1];
      s    = '0;
      s[0] = a[0] ^ (~a[1] & a[2]);
      s[1] = a[1] ^ (~a[2] & a[3]);
      s[2] = a[2] ^ (~a[3] & a[4]);
      s[3] = a[3] ^ (~a[4] & a[0]);
      s[4] = a[4] ^ (~a[0] & a[1]);
      s[1] = s[1] ^ s[0];
      s[0] = s[0] ^ s[4];
      s[3] = s[3] ^ s[2];
      s[2] = ~s[2];
   end

   assign y[0] = s[0] ^ ror(s[0], 19) ^ ror(s[0], 28);
   assign y[1] = s[1] ^ ror(s[1], 61) ^ ror(s[1], 39);
   assign y[2] = s[2] ^ ror(s[2], 1)  ^ ror(s[2], 6);
   assign y[3] = s[3] ^ ror(s[3], 10) ^ ror(s[3], 17);
   assign y[4] = s[4] ^ ror(s[4], 7)  ^ ror(s[4], 41);
endmodule

module ascon_dec (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [127:0] key,
   input  logic [127:0] nonce,
   input  logic [127:0] tag_in,
   input  logic         ad_empty,
   input  logic         ct_empty,
   input  logic         ad_valid,
   output logic         ad_ready,
   input  logic         ad_last,
   input  logic [63:0]  ad_data,
   input  logic         ct_valid,
   output logic         ct_ready,
   input  logic         ct_last,
   input  logic [63:0]  ct_data,
   output logic         pt_valid,
   input  logic         pt_ready,
   output logic [63:0]  pt_data,
   output logic         busy,
   output logic         done,
   output logic         tag_ok
);
   localparam logic [63:0] IV  = 64'h80400c0600000000;
   localparam logic [63:0] PAD = 64'h8000000000000000;

   typedef enum logic [3:0] {
      IDLE,
      INIT,
      POST_INIT,
      AD_WAIT,
      AD_PERM,
      AD_PAD,
      CT_WAIT,
      PT_OUT,
      CT_PERM,
      FIN_LOAD,
      FINAL,
      TAG
   } state_t;

   state_t           state;
   logic [4:0][63:0] x;
   logic [4:0][63:0] p_out;
   logic [127:0]     k_r;
   logic [127:0]     tag_r;
   logic             ad_empty_r;
   logic             ct_empty_r;
   logic             last_r;
   logic [3:0]       cnt;
   logic [3:0]       ridx;
   logic [7:0]       c_r;
   logic             twelve;
   logic             last_round;

   // six-round runs reuse the tail of the twelve-round constant schedule
   assign twelve     = (state == INIT) || (state == FINAL);
   assign ridx       = twelve ? cnt : cnt + 4'd6;
   assign c_r        = 8'hf0 - {ridx, 4'h0} + {4'h0, ridx};
   assign last_round = (cnt == (twelve ? 4'd11 : 4'd5));

   ascon_p u_p (
      .x   (x),
      .c_r (c_r),
      .y   (p_out)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         x          <= '0;
         k_r        <= '0;
         tag_r      <= '0;
         ad_empty_r <= 1'b0;
         ct_empty_r <= 1'b0;
         last_r     <= 1'b0;
         cnt        <= '0;
         ad_ready   <= 1'b0;
         ct_ready   <= 1'b0;
         pt_valid   <= 1'b0;
         pt_data    <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         tag_ok     <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  x[0]       <= IV;
                  x[1]       <= key[127:64];
                  x[2]       <= key[63:0];
                  x[3]       <= nonce[127:64];
                  x[4]       <= nonce[63:0];
                  k_r        <= key;
                  tag_r      <= tag_in;
                  ad_empty_r <= ad_empty;
                  ct_empty_r <= ct_empty;
                  cnt        <= '0;
                  busy       <= 1'b1;
                  tag_ok     <= 1'b0;
                  state      <= INIT;
               end
            end
            INIT: begin
               x   <= p_out;
               cnt <= cnt + 4'd1;
               if (last_round) begin
                  cnt   <= '0;
                  state <= POST_INIT;
               end
            end
            POST_INIT: begin
               x[3] <= x[3] ^ k_r[127:64];
               x[4] <= x[4] ^ k_r[63:0] ^ {63'd0, ad_empty_r};
               if (!ad_empty_r) begin
                  ad_ready <= 1'b1;
                  state    <= AD_WAIT;
               end else if (ct_empty_r) begin
                  state <= FIN_LOAD;
               end else begin
                  ct_ready <= 1'b1;
                  state    <= CT_WAIT;
               end
            end
            AD_WAIT: begin
               if (ad_valid && ad_ready) begin
                  x[0]     <= x[0] ^ ad_data;
                  last_r   <= ad_last;
                  ad_ready <= 1'b0;
                  cnt      <= '0;
                  state    <= AD_PERM;
               end
            end
            AD_PERM: begin
               x   <= p_out;
               cnt <= cnt + 4'd1;
               if (last_round) begin
                  cnt <= '0;
                  if (last_r) begin
                     x[0]  <= p_out[0] ^ PAD;
                     state <= AD_PAD;
                  end else begin
                     ad_ready <= 1'b1;
                     state    <= AD_WAIT;
                  end
               end
            end
            AD_PAD: begin
               x   <= p_out;
               cnt <= cnt + 4'd1;
               if (last_round) begin
                  cnt  <= '0;
                  x[4] <= p_out[4] ^ 64'd1;
                  if (ct_empty_r) begin
                     state <= FIN_LOAD;
                  end else begin
                     ct_ready <= 1'b1;
                     state    <= CT_WAIT;
                  end
               end
            end
            CT_WAIT: begin
               if (ct_valid && ct_ready) begin
                  pt_data  <= x[0] ^ ct_data;
                  x[0]     <= ct_data;
                  last_r   <= ct_last;
                  ct_ready <= 1'b0;
                  pt_valid <= 1'b1;
                  state    <= PT_OUT;
               end
            end
            PT_OUT: begin
               if (pt_ready) begin
                  pt_valid <= 1'b0;
                  cnt      <= '0;
                  state    <= CT_PERM;
               end
            end
            CT_PERM: begin
               x   <= p_out;
               cnt <= cnt + 4'd1;
               if (last_round) begin
                  cnt <= '0;
                  if (last_r) begin
                     state <= FIN_LOAD;
                  end else begin
                     ct_ready <= 1'b1;
                     state    <= CT_WAIT;
                  end
               end
            end
            FIN_LOAD: begin
               x[0]  <= x[0] ^ PAD;
               x[1]  <= x[1] ^ k_r[127:64];
               x[2]  <= x[2] ^ k_r[63:0];
               cnt   <= '0;
               state <= FINAL;
            end
            FINAL: begin
               x   <= p_out;
               cnt <= cnt + 4'd1;
               if (last_round) begin
                  cnt    <= '0;
                  done   <= 1'b1;
                  tag_ok <= ({p_out[3] ^ k_r[127:64],
                              p_out[4] ^ k_r[63:0]} == tag_r);
                  state  <= TAG;
               end
            end
            TAG: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ascon_dec.sv
// Randomised self-checking bench for ascon_dec.
// Expected plaintext, tags and latencies come from a software Ascon-128 model.
module tb_ascon_dec;
   localparam logic [63:0]  IV      = 64'h80400c0600000000;
   localparam logic [63:0]  PAD     = 64'h8000000000000000;
   localparam logic [127:0] KAT_K   = 128'h000102030405060708090A0B0C0D0E0F;
   localparam logic [127:0] KAT_TAG = 128'hE355159F292911F794CB1432A0103A8A;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [127:0] key;
   logic [127:0] nonce;
   logic [127:0] tag_in;
   logic         ad_empty;
   logic         ct_empty;
   logic         ad_valid;
   logic         ad_ready;
   logic         ad_last;
   logic [63:0]  ad_data;
   logic         ct_valid;
   logic         ct_ready;
   logic         ct_last;
   logic [63:0]  ct_data;
   logic         pt_valid;
   logic         pt_ready;
   logic [63:0]  pt_data;
   logic         busy;
   logic         done;
   logic         tag_ok;

   always #5 clk = ~clk;

   ascon_dec dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .key      (key),
      .nonce    (nonce),
      .tag_in   (tag_in),
      .ad_empty (ad_empty),
      .ct_empty (ct_empty),
      .ad_valid (ad_valid),
      .ad_ready (ad_ready),
      .ad_last  (ad_last),
      .ad_data  (ad_data),
      .ct_valid (ct_valid),
      .ct_ready (ct_ready),
      .ct_last  (ct_last),
      .ct_data  (ct_data),
      .pt_valid (pt_valid),
      .pt_ready (pt_ready),
      .pt_data  (pt_data),
      .busy     (busy),
      .done     (done),
      .tag_ok   (tag_ok)
   );

   int n_chk  = 0;
   int n_fail = 0;

   logic [63:0]  s [5];
   logic [63:0]  ad_q [$];
   logic [63:0]  pt_q [$];
   logic [63:0]  ct_q [$];
   logic [63:0]  exp_pt_q [$];
   logic [127:0] m_tag;

   task automatic check(input string tag, input logic [127:0] obs,
                        input logic [127:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
      return (v >> n) | (v << (64 - n));
   endfunction

   task automatic permute(input int rounds);
      logic [63:0] t [5];
      for (int r = 12 - rounds; r < 12; r++) begin
         s[2] ^= 64'((15 - r) * 16 + r);
         s[0] ^= s[4];
         s[4] ^= s[3];
         s[2] ^= s[1];
         for (int i = 0; i < 5; i++)
            t[i] = s[i] ^ (~s[(i + 1) % 5] & s[(i + 2) % 5]);
         t[1] ^= t[0];
         t[0] ^= t[4];
         t[3] ^= t[2];
         t[2] = ~t[2];
         s[0] = t[0] ^ rotr(t[0], 19) ^ rotr(t[0], 28);
         s[1] = t[1] ^ rotr(t[1], 61) ^ rotr(t[1], 39);
         s[2] = t[2] ^ rotr(t[2], 1) ^ rotr(t[2], 6);
         s[3] = t[3] ^ rotr(t[3], 10) ^ rotr(t[3], 17);
         s[4] = t[4] ^ rotr(t[4], 7) ^ rotr(t[4], 41);
      end
   endtask

   task automatic model_enc(input logic [127:0] k, input logic [127:0] n);
      s[0] = IV;
      s[1] = k[127:64];
      s[2] = k[63:0];
      s[3] = n[127:64];
      s[4] = n[63:0];
      permute(12);
      s[3] ^= k[127:64];
      s[4] ^= k[63:0];
      if (ad_q.size() > 0) begin
         foreach (ad_q[i]) begin
            s[0] ^= ad_q[i];
            permute(6);
         end
         s[0] ^= PAD;
         permute(6);
      end
      s[4] ^= 64'd1;
      ct_q.delete();
      foreach (pt_q[i]) begin
         s[0] ^= pt_q[i];
         ct_q.push_back(s[0]);
         permute(6);
      end
      s[0] ^= PAD;
      s[1] ^= k[127:64];
      s[2] ^= k[63:0];
      permute(12);
      m_tag = {s[3] ^ k[127:64], s[4] ^ k[63:0]};
   endtask

   task automatic make_msg(input int na, input int np,
                           input logic [127:0] k, input logic [127:0] n);
      ad_q.delete();
      pt_q.delete();
      repeat (na) ad_q.push_back({$urandom, $urandom});
      repeat (np) pt_q.push_back({$urandom, $urandom});
      model_enc(k, n);
      exp_pt_q = pt_q;
   endtask

   function automatic int lat(input int na, input int np, input int st);
      return 27 + ((na > 0) ? 7 * na + 6 : 0) + 8 * np + st * (na + np);
   endfunction

   // Caller is at a falling edge; start is sampled on the next rising edge.
   task automatic run_dec(input logic [127:0] k, input logic [127:0] n,
                          input logic [127:0] tg, input logic exp_ok,
                          input int stall, input logic toggle,
                          input int poke, input int exp_cyc);
      int   cyc, ai, ci, po, w_ad, w_ct, done_cyc;
      logic got, ok_seen;
      ai = 0; ci = 0; po = 0; w_ad = 0; w_ct = 0;
      done_cyc = -1; got = 1'b0; ok_seen = 1'b0;
      key = k; nonce = n; tag_in = tg;
      ad_empty = (ad_q.size() == 0);
      ct_empty = (ct_q.size() == 0);
      start = 1'b1;
      @(negedge clk);
      cyc = 1;
      key = ~k; nonce = ~n; tag_in = ~tg;
      ad_empty = ~ad_empty; ct_empty = ~ct_empty;
      check("busy_after_start", busy, 1'b1);
      while (!got && cyc < 3000) begin
         start = (cyc == poke);
         if (done === 1'b1) begin
            got = 1'b1;
            done_cyc = cyc;
            ok_seen = tag_ok;
         end
         if (ad_ready === 1'b1) begin
            if (w_ad < stall || ai >= ad_q.size()) begin
               ad_valid = 1'b0;
               w_ad++;
            end else begin
               ad_valid = 1'b1;
               ad_data = ad_q[ai];
               ad_last = (ai == ad_q.size() - 1);
               ai++;
               w_ad = 0;
            end
         end else begin
            ad_valid = 1'($urandom);
            ad_data = {$urandom, $urandom};
            ad_last = 1'($urandom);
         end
         if (ct_ready === 1'b1) begin
            if (w_ct < stall || ci >= ct_q.size()) begin
               ct_valid = 1'b0;
               w_ct++;
            end else begin
               ct_valid = 1'b1;
               ct_data = ct_q[ci];
               ct_last = (ci == ct_q.size() - 1);
               ci++;
               w_ct = 0;
            end
         end else begin
            ct_valid = 1'($urandom);
            ct_data = {$urandom, $urandom};
            ct_last = 1'($urandom);
         end
         pt_ready = toggle ? 1'($urandom) : 1'b1;
         if (pt_valid === 1'b1 && pt_ready) begin
            if (po < exp_pt_q.size())
               check($sformatf("pt_block%0d", po), pt_data, exp_pt_q[po]);
            else
               check("pt_extra", po, exp_pt_q.size());
            po++;
         end
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      ad_valid = 1'b0;
      ct_valid = 1'b0;
      check("done_seen", got, 1'b1);
      if (exp_cyc > 0) check("latency", done_cyc, exp_cyc);
      check("tag_ok", ok_seen, exp_ok);
      check("pt_count", po, exp_pt_q.size());
      check("done_pulse", done, 1'b0);
      check("busy_idle", busy, 1'b0);
      check("tag_ok_hold", tag_ok, exp_ok);
   endtask

   logic [127:0] k, n, tg;
   logic         ok, tgl;
   int           na, np, st, b;
   logic         seen;

   initial begin
      rst = 1'b1; start = 1'b0; key = '0; nonce = '0; tag_in = '0;
      ad_empty = 1'b0; ct_empty = 1'b0; ad_valid = 1'b0; ad_last = 1'b0;
      ad_data = '0; ct_valid = 1'b0; ct_last = 1'b0; ct_data = '0;
      pt_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_tag_ok", tag_ok, 1'b0);
      check("rst_pt_valid", pt_valid, 1'b0);
      check("rst_ad_ready", ad_ready, 1'b0);
      check("rst_ct_ready", ct_ready, 1'b0);
      check("rst_pt_data", pt_data, 64'd0);

      // known-answer vector, start in the first cycle out of reset
      make_msg(0, 0, KAT_K, KAT_K);
      check("kat_model", m_tag, KAT_TAG);
      rst = 1'b0;
      run_dec(KAT_K, KAT_K, KAT_TAG, 1'b1, 0, 1'b0, 0, 27);
      run_dec(KAT_K, KAT_K, KAT_TAG ^ 128'd1, 1'b0, 0, 1'b0, 0, 27);

      // 2 AD + 3 CT blocks, consumer back-pressure, then a tampered copy
      k = {$urandom, $urandom, $urandom, $urandom};
      n = {$urandom, $urandom, $urandom, $urandom};
      make_msg(2, 3, k, n);
      run_dec(k, n, m_tag, 1'b1, 0, 1'b1, 0, -1);
      b = $urandom_range(0, 63);
      ct_q[2] = ct_q[2] ^ (64'd1 << b);
      exp_pt_q[2] = exp_pt_q[2] ^ (64'd1 << b);
      run_dec(k, n, m_tag, 1'b0, 0, 1'b1, 0, -1);

      // timed runs: start poked mid-run, then 5-cycle stalls per block
      make_msg(2, 3, k, n);
      run_dec(k, n, m_tag, 1'b1, 0, 1'b0, 30, lat(2, 3, 0));
      run_dec(k, n, m_tag, 1'b1, 5, 1'b0, 0, lat(2, 3, 5));

      for (int it = 0; it < 6; it++) begin
         k = {$urandom, $urandom, $urandom, $urandom};
         n = {$urandom, $urandom, $urandom, $urandom};
         na = $urandom_range(0, 3);
         np = $urandom_range(0, 3);
         st = $urandom_range(0, 2);
         make_msg(na, np, k, n);
         tg = m_tag;
         ok = 1'($urandom);
         if (!ok) begin
            b = $urandom_range(0, 127);
            tg[b] = ~tg[b];
         end
         tgl = 1'($urandom);
         run_dec(k, n, tg, ok, st, tgl, 0, tgl ? -1 : lat(na, np, st));
      end

      make_msg(3, 0, k, n);
      run_dec(k, n, m_tag, 1'b1, 0, 1'b0, 0, lat(3, 0, 0));
      make_msg(0, 2, k, n);
      run_dec(k, n, m_tag, 1'b1, 0, 1'b0, 0, lat(0, 2, 0));

      // reset during round 5 of the finalisation permutation
      key = KAT_K; nonce = KAT_K; tag_in = KAT_TAG;
      ad_empty = 1'b1; ct_empty = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (18) @(negedge clk);
      check("busy_before_rst", busy, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_done", done, 1'b0);
      check("mid_rst_tag_ok", tag_ok, 1'b0);
      check("mid_rst_pt_valid", pt_valid, 1'b0);
      check("mid_rst_ad_ready", ad_ready, 1'b0);
      check("mid_rst_ct_ready", ct_ready, 1'b0);
      check("mid_rst_pt_data", pt_data, 64'd0);
      seen = 1'b0;
      repeat (30) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
      end
      check("no_activity_after_rst", seen, 1'b0);
      make_msg(0, 0, KAT_K, KAT_K);
      run_dec(KAT_K, KAT_K, KAT_TAG, 1'b1, 0, 1'b0, 0, 27);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/ascon_dec.md
ASCON_DEC -- requirements
Module: ascon_dec

Interface
REQ-001 SHALL have ports (name direction width meaning), clock and reset first:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin decryption; sampled in IDLE only
- key  in  128  K; sampled with start
- nonce  in  128  N; sampled with start
- tag_in  in  128  received tag; sampled with start
- ad_empty  in  1  no associated data; sampled with start
- ct_empty  in  1  no ciphertext; sampled with start
- ad_valid / ad_ready / ad_last  in/out/in  1  AD block handshake
- ad_data  in  64  AD block, full 8 bytes
- ct_valid / ct_ready / ct_last  in/out/in  1  ciphertext block handshake
- ct_data  in  64  ciphertext block, full 8 bytes
- pt_valid / pt_ready  out/in  1  plaintext block handshake
- pt_data  out  64  plaintext block
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse, result valid
- tag_ok  out  1  tag match; valid when done, held until next start
REQ-002 SHALL implement Ascon-128 decryption (rate 64, pa=12, pb=6), one round per cycle via one ascon_p instance fed by round constant c_r.
REQ-003 SHALL accept only full 64-bit AD/CT blocks; partial final blocks are out of scope.

Function
REQ-004 States: IDLE, INIT, POST_INIT, AD_WAIT, AD_PERM, AD_PAD, CT_WAIT, PT_OUT, CT_PERM, FIN_LOAD, FINAL, TAG.
REQ-005 IDLE, start=1: load x0=0x80400c0600000000, x1=K[127:64], x2=K[63:0], x3=N[127:64], x4=N[63:0]; go INIT.
REQ-006 Round i of a 12-round run uses c_r = 0xf0-0x0f*i (0xf0..0x4b); 6-round runs use last six (0x96..0x4b); 4-bit round counter, reset to 0 on each run entry.
REQ-007 INIT 12 cycles -> POST_INIT: x3^=K_hi, x4^=K_lo; if ad_empty also x4^=1 and go CT_WAIT (or FIN_LOAD if ct_empty), else AD_WAIT.
REQ-008 AD_WAIT: ad_ready=1; on ad_valid&ad_ready, x0^=ad_data, go AD_PERM (6 cycles), return AD_WAIT, or after ad_last go AD_PAD.
REQ-009 AD_PAD: x0^=0x8000000000000000, 6-round run, then x4^=1, go CT_WAIT (or FIN_LOAD if ct_empty).
REQ-010 CT_WAIT: ct_ready=1; on handshake, latch pt_data=x0^ct_data, set x0=ct_data, go PT_OUT.
REQ-011 PT_OUT: pt_valid=1, pt_data stable until pt_ready; then CT_PERM (6 cycles) -> CT_WAIT, or after ct_last -> FIN_LOAD.
REQ-012 FIN_LOAD 1 cycle: x0^=0x8000000000000000 (empty final pad), x1^=K_hi, x2^=K_lo; FINAL 12 rounds.
REQ-013 TAG 1 cycle: tag_ok=({x3^K_hi, x4^K_lo}==tag_in); done=1; next cycle IDLE.
REQ-014 ad_ready, ct_ready, pt_valid SHALL be low in all other states; at most one handshake per block.
REQ-015 start while busy SHALL be ignored; ad_*/ct_* inputs outside their wait states ignored.
REQ-016 Plaintext is released before tag check; tag_ok=0 means consumer discards it.
REQ-017 Empty-AD, empty-CT latency: start cycle 0, done high in cycle 27.
REQ-018 Each AD block costs 7 cycles min; each CT block 8 cycles min (pt_ready held high).

Reset
REQ-019 rst=1 at any edge, including mid-run: state IDLE, busy/done/tag_ok/pt_valid/ad_ready/ct_ready=0, pt_data=0, state words and counter=0; partial results lost.
REQ-020 First start SHALL be accepted the cycle after rst deasserts.

Verification
REQ-021 K=N=000102..0F, ad_empty=ct_empty=1, tag_in=E355159F292911F794CB1432A0103A8A -> done cycle 27, tag_ok=1, no pt_valid.
REQ-022 Same with tag_in bit 0 flipped -> done cycle 27, tag_ok=0.
REQ-023 Ciphertext from encrypting 2 AD + 3 PT blocks (golden model), pt_ready toggling 50% -> 3 pt blocks equal PT, tag_ok=1; tamper one ct bit -> tag_ok=0.
REQ-024 Stall: ad_valid/ct_valid low 5 cycles per block -> identical outputs, cycle count +5 per stall.
REQ-025 rst pulsed in FINAL round 5 -> all outputs 0 next cycle; fresh REQ-021 run then passes.
REQ-026 start pulsed while busy -> ignored, result unchanged.
